// File: rtl/wb_sequencer.sv
// Y86 write-back sequencer: serialises the valE and valM register writes through one RF port.
// Optional retirement counter on retired_o, enabled by defining WB_RETIRE_CNT_EN.
module wb_sequencer (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [3:0]  icode_i,
    input  logic [3:0]  rA_i,
    input  logic [3:0]  rB_i,
    input  logic        cnd_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valM_i,
    input  logic [1:0]  stat_i,
    output logic        rf_we_o,
    output logic [3:0]  rf_waddr_o,
    output logic [63:0] rf_wdata_o,
    output logic        done_o,
    output logic [1:0]  stat_o,
    output logic        halted_o
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retired_o
`endif
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_E,
        S_WR_M,
        S_DONE,
        S_HALT
    } state_t;

    state_t      r_state;
    logic [3:0]  r_dstM;
    logic [63:0] r_valM;
    logic [1:0]  r_stat;
    logic        r_ready;
    logic        r_we;
    logic [3:0]  r_waddr;
    logic [63:0] r_wdata;
    logic        r_done;
    logic        r_halted;
    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;

    always_comb begin
        w_dstE = REG_NONE;
        w_dstM = REG_NONE;
        case (icode_i)
            4'h2:                      w_dstE = cnd_i ? rB_i : REG_NONE;
            4'h3, 4'h6:                w_dstE = rB_i;
            4'h8, 4'h9, 4'hA, 4'hB:    w_dstE = REG_RSP;
            default:                   w_dstE = REG_NONE;
        endcase
        if (icode_i == 4'h5 || icode_i == 4'hB) begin
            w_dstM = rA_i;
        end
    end

    // Outputs are registered for the state being entered, so reset clears any write at once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_dstM   <= REG_NONE;
            r_valM   <= '0;
            r_stat   <= 2'b00;
            r_ready  <= 1'b1;
            r_we     <= 1'b0;
            r_waddr  <= REG_NONE;
            r_wdata  <= '0;
            r_done   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_waddr <= REG_NONE;
            r_wdata <= '0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_dstM  <= w_dstM;
                        r_valM  <= valM_i;
                        r_stat  <= stat_i;
                        r_ready <= 1'b0;
                        if (stat_i != 2'b00) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else if (w_dstE != REG_NONE) begin
                            r_state <= S_WR_E;
                            r_we    <= 1'b1;
                            r_waddr <= w_dstE;
                            r_wdata <= valE_i;
                        end else if (w_dstM != REG_NONE) begin
                            r_state <= S_WR_M;
                            r_we    <= 1'b1;
                            r_waddr <= w_dstM;
                            r_wdata <= valM_i;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_WR_E: begin
                    if (r_dstM != REG_NONE) begin
                        r_state <= S_WR_M;
                        r_we    <= 1'b1;
                        r_waddr <= r_dstM;
                        r_wdata <= r_valM;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_WR_M: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                S_HALT: begin
                    r_ready  <= 1'b0;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retired;

    // Halting instructions never pass through DONE, so they are not counted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_retired <= '0;
        end else if (r_state == S_DONE) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired_o = r_retired;
`endif

    assign ready_o    = r_ready;
    assign rf_we_o    = r_we;
    assign rf_waddr_o = r_waddr;
    assign rf_wdata_o = r_wdata;
    assign done_o     = r_done;
    assign stat_o     = r_stat;
    assign halted_o   = r_halted;

endmodule
